upload_frame_packer: RTL and testbench
======================================

Name: upload_frame_packer

Overview:
Transmit-side counterpart of the USB command parser. It collects upload bytes from a handler (UART, I2C, ...) over the upload_req/valid/ready interface and buffers them internally. When the burst ends, it emits one framed packet toward the USB uplink with header, source ID, 16-bit length, payload and checksum. It sits between the handlers' upload ports and the usb_upload_data/usb_upload_valid top-level outputs.

Parameters:
MAX_PAYLOAD_LEN, 256, payload buffer depth in bytes; a burst is cut into a frame at this size.
HEADER0, 8'hAA, first frame byte.
HEADER1, 8'h55, second frame byte.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
upload_req  input  1  handler holds high for the duration of an upload burst
upload_data  input  8  payload byte
upload_source  input  8  source ID, sampled at burst start
upload_valid  input  1  upload_data valid
upload_ready  output  1  packer accepts a byte when upload_valid & upload_ready
usb_upload_data  output  8  framed byte toward USB
usb_upload_valid  output  1  usb_upload_data valid
usb_upload_ready  input  1  USB side accepts the byte when valid & ready
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse after the checksum byte is accepted

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, count=0, checksum=0; all outputs 0. A partial frame is discarded. Buffer contents are don't-care.
- Frame format, in order: HEADER0, HEADER1, SRC, LEN[15:8], LEN[7:0], payload[0..LEN-1], CSUM.
  - CSUM = (SRC + LEN[15:8] + LEN[7:0] + sum of payload bytes) mod 256.
  - Header bytes are excluded from CSUM.
- States: IDLE, COLLECT, HDR0, HDR1, SRC, LENH, LENL, PAYLOAD, CSUM.
- IDLE:
  - upload_ready=0.
  - If upload_req=1: latch upload_source and go to COLLECT next cycle.
- COLLECT:
  - upload_ready = (count < MAX_PAYLOAD_LEN).
  - On valid & ready: write the byte to buffer[count], increment count (9+ bit counter), add the byte into the running sum.
  - A handshake in the same cycle that upload_req falls is still accepted.
  - Exit to HDR0 when upload_req=0 (after that cycle's accept) with count>0.
  - Exit to HDR0 when count reaches MAX_PAYLOAD_LEN, even if upload_req is still 1.
  - If upload_req=0 and count=0 (empty burst): return to IDLE, emit no frame.
  - Changes on upload_source during COLLECT are ignored.
- Transmit states (HDR0 through CSUM):
  - usb_upload_valid=1 with the current byte.
  - Advance one byte per cycle when usb_upload_ready=1.
  - While usb_upload_ready=0, usb_upload_data and usb_upload_valid hold stable.
  - With ready held high, the frame occupies exactly LEN+6 consecutive valid cycles.
  - upload_ready=0 throughout.
- PAYLOAD:
  - Reads the buffer in order 0..LEN-1.
  - A synchronous-read RAM is used; the read is prefetched so there are no bubbles when ready is held high.
- CSUM accepted:
  - frame_done=1 for one cycle, count cleared, state goes to IDLE.
  - If upload_req is still high, a new frame starts via IDLE on the next cycle.
  - This is also how a cut-at-MAX burst continues.
- Latency: first HEADER0 valid appears 1 cycle after the COLLECT exit condition.
- usb_upload_valid never rises outside transmit states. No byte is dropped or duplicated under arbitrary ready patterns.

Test Plan:
1. Basic frame: req high, source=0x01, bytes 0x11 0x22 0x33, req low, usb_upload_ready=1 -> output AA 55 01 00 03 11 22 33 6A on 9 consecutive cycles; frame_done pulses once.
2. Backpressure: same frame with usb_upload_ready toggling 1,0,0,1 repeatedly -> identical byte sequence; data stable during every stall; no extra or missing valid-ready handshakes.
3. Checksum wrap: source=0xFF, payload FF 80 -> AA 55 FF 00 02 FF 80 80.
4. Buffer full: 300 bytes offered with req held high -> upload_ready drops after byte 256; first frame has LEN bytes 01 00. After frame_done, the remaining 44 bytes form a second frame with LEN 00 2C.
5. Empty burst: req high 3 cycles with no valid, then low -> no usb_upload_valid; busy returns to 0 and state returns to IDLE.
6. Reset mid-frame: assert rst during PAYLOAD -> all outputs 0 immediately. A new 1-byte burst (src 0x05, data 0x10) afterwards produces AA 55 05 00 01 10 16.

Source files
------------

// File: rtl/upload_frame_packer.sv
// Upload frame packer: buffers a handler's upload burst, then sends it
// to the USB uplink as AA 55 SRC LENH LENL payload CSUM.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   upload_req         burst in progress (held high by the handler)
//   upload_data        payload byte from the handler
//   upload_source      source ID, latched when the burst starts
//   upload_valid       upload_data valid
//   upload_ready       packer accepts a byte (valid & ready)
//   usb_upload_data    framed byte toward the USB uplink
//   usb_upload_valid   usb_upload_data valid
//   usb_upload_ready   uplink accepts the byte (valid & ready)
//   busy               packer is not idle
//   frame_done         one-cycle pulse after the checksum byte is taken
module upload_frame_packer #(
    parameter int         MAX_PAYLOAD_LEN = 256,
    parameter logic [7:0] HEADER0         = 8'hAA,
    parameter logic [7:0] HEADER1         = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upload_req,
    input  logic [7:0] upload_data,
    input  logic [7:0] upload_source,
    input  logic       upload_valid,
    output logic       upload_ready,
    output logic [7:0] usb_upload_data,
    output logic       usb_upload_valid,
    input  logic       usb_upload_ready,
    output logic       busy,
    output logic       frame_done
);
    localparam int AW = (MAX_PAYLOAD_LEN > 1) ? $clog2(MAX_PAYLOAD_LEN) : 1;
    localparam int CW = $clog2(MAX_PAYLOAD_LEN + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_COLLECT, S_HDR0, S_HDR1, S_SRC,
        S_LENH, S_LENL, S_PAYLOAD, S_CSUM
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic [7:0]    sum;
    logic [7:0]    src;
    logic [7:0]    rdata;
    logic [7:0]    csum;
    logic [15:0]   len;
    logic [AW-1:0] idx;
    logic [AW-1:0] rd_addr;
    logic          accept;
    logic          advance;
    logic          last;

    logic [7:0] mem [MAX_PAYLOAD_LEN];

    assign accept    = upload_valid & upload_ready;
    assign count_inc = count + CW'(accept);
    assign len       = 16'(count);
    assign csum      = sum + src + len[15:8] + len[7:0];
    assign advance   = usb_upload_valid & usb_upload_ready;
    assign last      = (CW'(idx) + CW'(1)) == count;

    // Prefetch: rdata always holds mem[idx] for the byte on the bus, and
    // the next address is presented in the same cycle the current byte
    // is accepted, so payload bytes stream without bubbles.
    always_comb begin
        rd_addr = idx;
        if (state == S_PAYLOAD && advance && !last)
            rd_addr = idx + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (state == S_COLLECT && accept)
            mem[count[AW-1:0]] <= upload_data;
        rdata <= mem[rd_addr];
    end

    always_comb begin
        usb_upload_data = 8'h00;
        case (state)
            S_HDR0:    usb_upload_data = HEADER0;
            S_HDR1:    usb_upload_data = HEADER1;
            S_SRC:     usb_upload_data = src;
            S_LENH:    usb_upload_data = len[15:8];
            S_LENL:    usb_upload_data = len[7:0];
            S_PAYLOAD: usb_upload_data = rdata;
            S_CSUM:    usb_upload_data = csum;
            default:   usb_upload_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            count            <= '0;
            sum              <= 8'h00;
            src              <= 8'h00;
            idx              <= '0;
            upload_ready     <= 1'b0;
            usb_upload_valid <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (upload_req) begin
                        src          <= upload_source;
                        count        <= '0;
                        sum          <= 8'h00;
                        state        <= S_COLLECT;
                        busy         <= 1'b1;
                        upload_ready <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        count <= count_inc;
                        sum   <= sum + upload_data;
                    end
                    // A byte taken in the cycle req falls still counts.
                    if (count_inc == MAX_CNT ||
                        (!upload_req && count_inc != '0)) begin
                        state            <= S_HDR0;
                        idx              <= '0;
                        upload_ready     <= 1'b0;
                        usb_upload_valid <= 1'b1;
                    end else if (!upload_req) begin
                        state        <= S_IDLE;
                        upload_ready <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                S_HDR0: if (usb_upload_ready) state <= S_HDR1;
                S_HDR1: if (usb_upload_ready) state <= S_SRC;
                S_SRC:  if (usb_upload_ready) state <= S_LENH;
                S_LENH: if (usb_upload_ready) state <= S_LENL;
                S_LENL: if (usb_upload_ready) state <= S_PAYLOAD;
                S_PAYLOAD: begin
                    if (usb_upload_ready) begin
                        if (last) state <= S_CSUM;
                        else      idx   <= idx + AW'(1);
                    end
                end
                S_CSUM: begin
                    if (usb_upload_ready) begin
                        state            <= S_IDLE;
                        count            <= '0;
                        sum              <= 8'h00;
                        usb_upload_valid <= 1'b0;
                        busy             <= 1'b0;
                        frame_done       <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_upload_frame_packer.sv
// Testbench for upload_frame_packer: directed bursts plus random bursts,
// checked byte-by-byte against a frame model built from the payload.
module tb_upload_frame_packer;
    logic       clk = 1'b0;
    logic       rst;
    logic       upload_req;
    logic [7:0] upload_data;
    logic [7:0] upload_source;
    logic       upload_valid;
    logic       upload_ready;
    logic [7:0] usb_upload_data;
    logic       usb_upload_valid;
    logic       usb_upload_ready;
    logic       busy;
    logic       frame_done;

    upload_frame_packer dut (
        .clk              (clk),
        .rst              (rst),
        .upload_req       (upload_req),
        .upload_data      (upload_data),
        .upload_source    (upload_source),
        .upload_valid     (upload_valid),
        .upload_ready     (upload_ready),
        .usb_upload_data  (usb_upload_data),
        .usb_upload_valid (usb_upload_valid),
        .usb_upload_ready (usb_upload_ready),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected byte stream and per-frame sizes.
    logic [7:0] exp_q[$];
    int         fsz[$];
    logic [7:0] pay[$];

    function automatic void add_frames(input logic [7:0] s);
        int n;
        int start;
        int l;
        int acc;
        n = pay.size();
        start = 0;
        while (start < n) begin
            l = (n - start > 256) ? 256 : n - start;
            exp_q.push_back(8'hAA);
            exp_q.push_back(8'h55);
            exp_q.push_back(s);
            exp_q.push_back(8'(l / 256));
            exp_q.push_back(8'(l % 256));
            acc = s + (l / 256) + (l % 256);
            for (int i = 0; i < l; i++) begin
                exp_q.push_back(pay[start + i]);
                acc += pay[start + i];
            end
            exp_q.push_back(8'(acc % 256));
            fsz.push_back(l + 6);
            start += l;
        end
    endfunction

    // Uplink ready pattern: 0 always, 1 repeating 1,0,0,1, 2 random.
    int mode = 0;
    int pat  = 0;
    initial begin
        usb_upload_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: usb_upload_ready = 1'b1;
                1: begin
                    usb_upload_ready = (pat % 4 == 0) || (pat % 4 == 3);
                    pat++;
                end
                default: usb_upload_ready = 1'($urandom % 2);
            endcase
        end
    end

    // Uplink monitor, sampled on the falling edge.
    int         nb       = 0;
    int         cyc      = 0;
    bit         in_frame = 0;
    bit         pend     = 0;
    bit         hold     = 0;
    logic [7:0] hold_d   = 8'h00;
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pend || frame_done)
                    chk("frame_done", 32'(frame_done), 32'(pend));
                pend = 0;
                if (hold) begin
                    chk("hold_valid", 32'(usb_upload_valid), 1);
                    chk("hold_data", 32'(usb_upload_data), 32'(hold_d));
                end
                hold   = usb_upload_valid && !usb_upload_ready;
                hold_d = usb_upload_data;
                if (usb_upload_valid && !in_frame) begin
                    in_frame = 1;
                    cyc = 0;
                end
                if (in_frame) cyc++;
                if (usb_upload_valid && usb_upload_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_byte", 32'(usb_upload_data), 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", 32'(usb_upload_data), 32'(e));
                        nb++;
                        if (nb == fsz[0]) begin
                            if (mode == 0)
                                chk("frame_cycles", 32'(cyc), 32'(fsz[0]));
                            void'(fsz.pop_front());
                            nb = 0;
                            in_frame = 0;
                            pend = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] s, input bit gaps, input bit drop);
        int to;
        int n;
        n = pay.size();
        add_frames(s);
        @(posedge clk);
        #1;
        upload_req    = 1'b1;
        upload_source = s;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            // Source changes mid-burst must not reach the frame.
            if (i > 0 && n <= 256 && ($urandom % 2) == 1)
                upload_source = 8'($urandom);
            upload_data  = pay[i];
            upload_valid = 1'b1;
            to = 0;
            forever begin
                @(negedge clk);
                if (upload_ready) begin
                    if (drop && i == n - 1) upload_req = 1'b0;
                    break;
                end
                to++;
                if (to > 5000) begin
                    chk("accept_timeout", 32'(i), 32'(n));
                    upload_valid = 1'b0;
                    upload_req   = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            upload_valid = 1'b0;
            if ((i + 1) % 256 == 0 && i + 1 < n)
                chk("full_ready", 32'(upload_ready), 0);
        end
        upload_req   = 1'b0;
        upload_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int to;
        to = 0;
        while ((exp_q.size() != 0 || busy) && to < 10000) begin
            @(posedge clk);
            to++;
        end
        chk("idle_timeout", 32'(to >= 10000), 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int to;
        rst           = 1'b1;
        upload_req    = 1'b0;
        upload_data   = 8'h00;
        upload_source = 8'h00;
        upload_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_upload_ready", 32'(upload_ready), 0);
        chk("rst_usb_valid", 32'(usb_upload_valid), 0);
        chk("rst_usb_data", 32'(usb_upload_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        mode = 0;
        pay = '{8'h11, 8'h22, 8'h33};
        send(8'h01, 0, 0);
        wait_idle();

        mode = 1;
        pat = 0;
        send(8'h01, 0, 0);
        wait_idle();

        mode = 0;
        pay = '{8'hFF, 8'h80};
        send(8'hFF, 0, 1);
        wait_idle();

        pay.delete();
        for (int i = 0; i < 300; i++) pay.push_back(8'($urandom));
        send(8'h42, 0, 0);
        wait_idle();

        @(posedge clk);
        #1;
        upload_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("empty_busy_hi", 32'(busy), 1);
        upload_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("empty_busy_lo", 32'(busy), 0);
        chk("empty_valid", 32'(usb_upload_valid), 0);

        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(8'($urandom));
        send(8'h33, 0, 0);
        to = 0;
        while (nb < 8 && to < 500) begin
            @(posedge clk);
            to++;
        end
        chk("reach_payload", 32'(nb >= 8), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(usb_upload_valid), 0);
        chk("mid_rst_data", 32'(usb_upload_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(upload_ready), 0);
        exp_q.delete();
        fsz.delete();
        nb = 0;
        in_frame = 0;
        pend = 0;
        hold = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        pay = '{8'h10};
        send(8'h05, 0, 0);
        wait_idle();

        for (int k = 0; k < 12; k++) begin
            mode = $urandom_range(0, 2);
            pay.delete();
            if ($urandom % 4 == 0)
                for (int i = 0; i < $urandom_range(250, 270); i++)
                    pay.push_back(8'($urandom));
            else
                for (int i = 0; i < $urandom_range(1, 40); i++)
                    pay.push_back(8'($urandom));
            send(8'($urandom), 1'($urandom % 2), 1'($urandom % 2));
            wait_idle();
        end

        chk("missing_bytes", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
